usage_reminder: RTL and testbench
=================================

// Module: usage_reminder
// PURPOSE
//   Accumulates appliance running time (h:m:s) and raises a cleaning reminder once it reaches
//   the limit produced by timer_setter (hours/minutes). Sits directly downstream of timer_setter;
//   its outputs drive the reminder LED and the display mux. A clean-done pulse restarts the count.
// PARAMETERS
//   TICK_CYCLES  100_000_000  clk cycles per accumulated second (100 MHz board clock)
//   MAX_HOURS    99           saturation value of acc_hours
// PORTS
//   clk            in   1  system clock, single clock domain
//   reset          in   1  asynchronous, active-high reset
//   power_on       in   1  appliance powered; low = IDLE, counting halted
//   running        in   1  motor/fan active; time accumulates only while high
//   limit_hours    in   6  reminder threshold hours from timer_setter, 0..23
//   limit_minutes  in   6  reminder threshold minutes from timer_setter, 0..59
//   clean_done     in   1  debounced level from clean-confirm key; acted on at rising edge
//   acc_hours      out  7  accumulated hours, 0..MAX_HOURS
//   acc_minutes    out  6  accumulated minutes, 0..59
//   acc_seconds    out  6  accumulated seconds, 0..59
//   remind         out  1  high while state == ALERT
//   remind_blink   out  1  toggles every TICK_CYCLES/2 in ALERT, 0 otherwise
// BEHAVIOUR
//   - Reset: all acc_* = 0, remind = 0, remind_blink = 0, prescaler = 0, state = IDLE.
//   - States: IDLE, COUNT, ALERT. IDLE->COUNT when power_on; COUNT/ALERT->IDLE when !power_on.
//     IDLE keeps acc_* (usage persists across power cycles); leaving IDLE re-evaluates the limit.
//   - Prescaler counts 0..TICK_CYCLES-1 only when power_on && running && state==COUNT; pauses
//     (holds value) otherwise; 1-cycle tick on wrap.
//   - On tick: seconds+1; 59->0 carries minutes; minutes 59->0 carries hours. At 99:59:59 the
//     counter saturates (no wrap, no further change).
//   - Compare: limit_total = limit_hours*60+limit_minutes (11 bit), acc_total = acc_hours*60+
//     acc_minutes (13 bit). limit_total == 0 disables reminder. Seconds ignored.
//   - COUNT->ALERT the cycle after acc_total >= limit_total (enabled); remind rises that edge,
//     i.e. 1 cycle after the tick that completes the crossing minute.
//   - ALERT: counting stops. If limit raised so acc_total < limit_total, or limit set to 0,
//     ALERT->COUNT next cycle.
//   - clean_done rising edge (registered edge detect) while power_on: all acc_* and prescaler
//     cleared, state -> COUNT next cycle, remind low. Ignored in IDLE (edge still consumed).
//   - Simultaneous tick and clean_done edge: clear wins. Simultaneous power_off and clean
//     edge: IDLE wins, counters not cleared.
//   - remind_blink: half-period counter runs only in ALERT, starts at 0 with blink=0 on entry;
//     forced 0 and counter cleared on any exit from ALERT.
//   - Reset asserted mid-operation returns every register to reset values immediately.
// STRUCTURE
//   - Shared package: state encoding (IDLE/COUNT/ALERT), TICK_CYCLES default, MAX_HOURS,
//     SECS_PER_MIN/MINS_PER_HOUR = 60.
//   - One sub-module: tick_prescaler (enable, clear, TICK_CYCLES param -> 1-cycle tick).
//     Blink divider reuses tick_prescaler with TICK_CYCLES/2.
// TESTING  (bench uses TICK_CYCLES=10)
//   1 reset high mid-count at 00:03:17 -> all outputs 0, state IDLE; release, power_on=0 -> stays 0.
//   2 power_on=running=1, limit 00:02 -> remind rises 1 cycle after acc reaches 00:02:00
//     (120 ticks); acc frozen thereafter; remind_blink toggles every 5 cycles.
//   3 running toggled low for 37 cycles mid-second -> prescaler holds; total ticks delayed by
//     exactly 37 cycles; power_on=0 at 00:01:30 then 1 -> resumes from 00:01:30.
//   4 in ALERT at 00:02, raise limit to 00:05 -> remind drops next cycle, counting resumes;
//     limit 00:00 -> never alerts, acc counts to 99:59:59 and saturates (force-load acc).
//   5 clean_done pulse in ALERT -> acc 00:00:00, remind/blink 0, COUNT next cycle; held high
//     10 cycles -> only one clear; pulse coincident with tick -> acc 00:00:00.
//   6 clean_done edge with power_on=0 -> acc unchanged; power_off coincident with edge -> unchanged.

Source files
------------

// File: rtl/usage_reminder_pkg.sv
// Shared definitions for the appliance usage reminder: FSM states, timing defaults
// and the h:m to total-minutes helper used by the limit comparison.
package usage_reminder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ALERT = 2'd2
    } state_t;

    localparam int TICK_CYCLES_DEFAULT = 100_000_000;
    localparam int MAX_HOURS_DEFAULT   = 99;
    localparam int SECS_PER_MIN        = 60;
    localparam int MINS_PER_HOUR       = 60;

    function automatic logic [12:0] total_minutes(input logic [6:0] hours,
                                                  input logic [5:0] minutes);
        return 13'(hours) * 13'(MINS_PER_HOUR) + 13'(minutes);
    endfunction

endpackage

// File: rtl/usage_reminder_tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_CYCLES enabled cycles.
// The count holds while enable is low and returns to zero on clear.
module tick_prescaler #(
    parameter int TICK_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/usage_reminder.sv
// Accumulates appliance running time as h:m:s and raises a cleaning reminder once the
// accumulated minutes reach the limit from timer_setter; a clean-done edge restarts the count.
module usage_reminder
    import usage_reminder_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEFAULT,
    parameter int MAX_HOURS   = MAX_HOURS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       running,
    input  logic [5:0] limit_hours,
    input  logic [5:0] limit_minutes,
    input  logic       clean_done,
    output logic [6:0] acc_hours,
    output logic [5:0] acc_minutes,
    output logic [5:0] acc_seconds,
    output logic       remind,
    output logic       remind_blink
);

    localparam int BLINK_CYCLES = (TICK_CYCLES >= 2) ? TICK_CYCLES / 2 : 1;
    localparam logic [5:0] LAST_SEC = 6'(SECS_PER_MIN - 1);
    localparam logic [5:0] LAST_MIN = 6'(MINS_PER_HOUR - 1);
    localparam logic [6:0] TOP_HOUR = 7'(MAX_HOURS);

    state_t      state;
    state_t      next_state;
    logic        clean_prev;
    logic        clean_rise;
    logic        do_clear;
    logic        count_en;
    logic        sec_tick;
    logic        blink_tick;
    logic        at_max;
    logic        limit_hit;
    logic [10:0] limit_total;
    logic [12:0] acc_total;

    assign clean_rise  = clean_done && !clean_prev;
    assign do_clear    = clean_rise && power_on && (state != ST_IDLE);
    assign count_en    = power_on && running && (state == ST_COUNT);
    assign limit_total = 11'(limit_hours) * 11'(MINS_PER_HOUR) + 11'(limit_minutes);
    assign acc_total   = total_minutes(acc_hours, acc_minutes);
    assign limit_hit   = (limit_total != 11'd0) && (acc_total >= 13'(limit_total));
    assign at_max      = (acc_hours == TOP_HOUR) && (acc_minutes == LAST_MIN) &&
                         (acc_seconds == LAST_SEC);
    assign remind      = (state == ST_ALERT);

    tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_sec_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (count_en),
        .clear  (do_clear),
        .tick   (sec_tick)
    );

    // The blink divider only runs inside ALERT so every entry starts from a clean phase.
    tick_prescaler #(.TICK_CYCLES(BLINK_CYCLES)) u_blink_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (state == ST_ALERT),
        .clear  (next_state != ST_ALERT),
        .tick   (blink_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            clean_prev <= 1'b0;
        end else begin
            state      <= next_state;
            clean_prev <= clean_done;
        end
    end

    // Power loss dominates a clean request; otherwise a clean restarts counting.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (power_on) next_state = ST_COUNT;
            end
            ST_COUNT: begin
                if (!power_on)      next_state = ST_IDLE;
                else if (clean_rise) next_state = ST_COUNT;
                else if (limit_hit)  next_state = ST_ALERT;
            end
            ST_ALERT: begin
                if (!power_on)                     next_state = ST_IDLE;
                else if (clean_rise || !limit_hit) next_state = ST_COUNT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_hours   <= '0;
            acc_minutes <= '0;
            acc_seconds <= '0;
        end else if (do_clear) begin
            acc_hours   <= '0;
            acc_minutes <= '0;
            acc_seconds <= '0;
        end else if (sec_tick && !at_max) begin
            if (acc_seconds != LAST_SEC) begin
                acc_seconds <= acc_seconds + 6'd1;
            end else begin
                acc_seconds <= '0;
                if (acc_minutes != LAST_MIN) begin
                    acc_minutes <= acc_minutes + 6'd1;
                end else begin
                    acc_minutes <= '0;
                    acc_hours   <= acc_hours + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remind_blink <= 1'b0;
        end else if (next_state != ST_ALERT) begin
            remind_blink <= 1'b0;
        end else if (blink_tick) begin
            remind_blink <= ~remind_blink;
        end
    end

endmodule

// File: tb/tb_usage_reminder.sv
// Randomised and directed bench for usage_reminder, checked every cycle against a model
// that keeps usage as a single seconds count and derives h:m:s and the limit from it.
module tb_usage_reminder;

    localparam int TICK     = 10;
    localparam int MAX_SECS = 99 * 3600 + 59 * 60 + 59;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_on;
    logic       running;
    logic [5:0] limit_hours;
    logic [5:0] limit_minutes;
    logic       clean_done;
    logic [6:0] acc_hours;
    logic [5:0] acc_minutes;
    logic [5:0] acc_seconds;
    logic       remind;
    logic       remind_blink;

    logic       p2;
    logic [6:0] h2;
    logic [5:0] m2;
    logic [5:0] s2;
    logic       rem2;
    logic       blk2;

    int total_checks  = 0;
    int passed_checks = 0;

    int m_usage;
    int m_phase;
    int m_bphase;
    bit m_active;
    bit m_alert;
    bit m_blink;
    bit m_clean_prev;

    usage_reminder #(.TICK_CYCLES(TICK), .MAX_HOURS(99)) dut (
        .clk           (clk),
        .reset         (reset),
        .power_on      (power_on),
        .running       (running),
        .limit_hours   (limit_hours),
        .limit_minutes (limit_minutes),
        .clean_done    (clean_done),
        .acc_hours     (acc_hours),
        .acc_minutes   (acc_minutes),
        .acc_seconds   (acc_seconds),
        .remind        (remind),
        .remind_blink  (remind_blink)
    );

    // Fast, low-ceiling instance so saturation is reachable in a short run.
    usage_reminder #(.TICK_CYCLES(2), .MAX_HOURS(1)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .power_on      (p2),
        .running       (1'b1),
        .limit_hours   (6'd0),
        .limit_minutes (6'd0),
        .clean_done    (1'b0),
        .acc_hours     (h2),
        .acc_minutes   (m2),
        .acc_seconds   (s2),
        .remind        (rem2),
        .remind_blink  (blk2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_usage      = 0;
        m_phase      = 0;
        m_bphase     = 0;
        m_active     = 0;
        m_alert      = 0;
        m_blink      = 0;
        m_clean_prev = 0;
    endfunction

    function automatic void model_edge();
        int lim;
        bit rise, reached, counting, clear, n_active, n_alert;
        lim      = int'(limit_hours) * 60 + int'(limit_minutes);
        rise     = clean_done && !m_clean_prev;
        reached  = (lim != 0) && (m_usage / 60 >= lim);
        counting = power_on && running && m_active && !m_alert;
        clear    = rise && power_on && m_active;
        n_active = power_on;
        if (!m_active || !power_on || clear) n_alert = 0;
        else n_alert = reached;
        if (n_alert && m_alert) begin
            if (m_bphase == TICK / 2 - 1) begin
                m_bphase = 0;
                m_blink  = !m_blink;
            end else begin
                m_bphase++;
            end
        end else begin
            m_bphase = 0;
            m_blink  = 0;
        end
        if (clear) begin
            m_usage = 0;
            m_phase = 0;
        end else if (counting) begin
            if (m_phase == TICK - 1) begin
                m_phase = 0;
                if (m_usage < MAX_SECS) m_usage++;
            end else begin
                m_phase++;
            end
        end
        m_alert      = n_alert;
        m_active     = n_active;
        m_clean_prev = clean_done;
    endfunction

    task automatic check_output();
        check_val("acc_hours",    32'(acc_hours),    m_usage / 3600);
        check_val("acc_minutes",  32'(acc_minutes),  (m_usage / 60) % 60);
        check_val("acc_seconds",  32'(acc_seconds),  m_usage % 60);
        check_val("remind",       32'(remind),       32'(m_alert));
        check_val("remind_blink", 32'(remind_blink), 32'(m_blink));
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_output();
    endtask

    task automatic run_until_usage(input int target, input int budget);
        int n = 0;
        while (m_usage != target && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_val("usage_reached", m_usage, target);
    endtask

    task automatic wait_remind(input int budget, output int n);
        n = 0;
        while (remind !== 1'b1 && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_val("remind_timeout", 32'(remind), 1);
    endtask

    initial begin
        int n;
        int saved;
        bit rem_seen;

        reset = 1; power_on = 0; running = 0; clean_done = 0; p2 = 0;
        limit_hours = 0; limit_minutes = 0;
        model_reset();
        apply_stimulus();
        apply_stimulus();
        reset = 0;

        $display("[TB] reset mid-count");
        power_on = 1; running = 1;
        run_until_usage(197, 2500);
        #2; reset = 1; power_on = 0; running = 0;
        #1; model_reset();
        check_output();
        apply_stimulus();
        reset = 0;
        repeat (20) apply_stimulus();

        $display("[TB] pause and power cycle");
        limit_minutes = 2; power_on = 1; running = 1;
        run_until_usage(45, 600);
        repeat (3) apply_stimulus();
        running = 0;
        repeat (37) apply_stimulus();
        running = 1;
        run_until_usage(90, 600);
        power_on = 0;
        repeat (15) apply_stimulus();
        check_val("resume_s", 32'(acc_seconds), 30);
        check_val("resume_m", 32'(acc_minutes), 1);
        power_on = 1;
        wait_remind(700, n);
        repeat (30) apply_stimulus();

        $display("[TB] limit raise and clean");
        limit_minutes = 5;
        apply_stimulus();
        check_val("remind_drop", 32'(remind), 0);
        repeat (20) apply_stimulus();
        limit_minutes = 2;
        repeat (5) apply_stimulus();
        clean_done = 1;
        apply_stimulus();
        check_val("clean_seconds", 32'(acc_seconds), 0);
        repeat (9) apply_stimulus();
        clean_done = 0;
        wait_remind(1400, n);
        check_val("remind_latency", n, 1192);

        limit_minutes = 5;
        repeat (3) apply_stimulus();
        n = 0;
        while (m_phase != TICK - 1 && n < 20) begin
            apply_stimulus();
            n++;
        end
        check_val("tick_aligned", m_phase, TICK - 1);
        clean_done = 1;
        apply_stimulus();
        check_val("coinc_clear_s", 32'(acc_seconds), 0);
        check_val("coinc_clear_m", 32'(acc_minutes), 0);
        clean_done = 0;
        repeat (50) apply_stimulus();

        $display("[TB] clean while unpowered");
        saved = m_usage;
        power_on = 0;
        repeat (3) apply_stimulus();
        clean_done = 1;
        repeat (3) apply_stimulus();
        clean_done = 0;
        check_val("idle_clean_keep", 32'(acc_seconds) + 60 * 32'(acc_minutes), saved);
        power_on = 1;
        repeat (30) apply_stimulus();
        saved = m_usage;
        power_on = 0; clean_done = 1;
        apply_stimulus();
        check_val("off_clean_keep", 32'(acc_seconds) + 60 * 32'(acc_minutes), saved);
        clean_done = 0;
        repeat (5) apply_stimulus();

        $display("[TB] random phase");
        for (int i = 0; i < 800; i++) begin
            power_on = ($urandom_range(0, 19) != 0);
            running  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) clean_done = ~clean_done;
            if ($urandom_range(0, 99) == 0) limit_minutes = 6'($urandom_range(0, 2));
            apply_stimulus();
        end

        $display("[TB] saturation");
        power_on = 0; clean_done = 0;
        p2 = 1; n = 0; rem_seen = 0;
        while (!(h2 == 7'd1 && m2 == 6'd59 && s2 == 6'd59) && n < 16000) begin
            apply_stimulus();
            n++;
            if (rem2 || blk2) rem_seen = 1;
            if (n == 7201) begin
                check_val("carry_h", 32'(h2), 1);
                check_val("carry_m", 32'(m2), 0);
                check_val("carry_s", 32'(s2), 0);
            end
        end
        check_val("sat_cycles", n, 14399);
        repeat (10) apply_stimulus();
        check_val("sat_h", 32'(h2), 1);
        check_val("sat_m", 32'(m2), 59);
        check_val("sat_s", 32'(s2), 59);
        check_val("sat_no_remind", 32'(rem_seen), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
